irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt controller for the core: latches up to NUM_SRC interrupt lines, masks them
//  with a software-written enable register, picks the highest-index eligible source and
//  presents it to the core with a request/ack/end-of-interrupt handshake.
//  Sits between peripheral IRQ lines and the core's trap logic. One interrupt in service at a time.
// PARAMETERS
//  NUM_SRC    16      number of interrupt sources, 2..32
//  EDGE_MASK  16'h0   bit i = 1: source i is rising-edge triggered; 0: level triggered
//  ID_W       4       width of source IDs, = $clog2(NUM_SRC)
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  irq_src     in   NUM_SRC  raw interrupt lines
//  cfg_we      in   1        write enable for irq_en register
//  cfg_wdata   in   NUM_SRC  new enable mask
//  irq_ack     in   1        core claims the presented interrupt
//  eoi         in   1        core signals end of interrupt, 1-cycle pulse
//  eoi_id      in   ID_W     ID being completed
//  irq_req     out  1        interrupt presented to core
//  irq_id      out  ID_W     ID of presented interrupt, valid while irq_req=1
//  active_id   out  ID_W     ID in service, valid while busy=1
//  busy        out  1        an interrupt is in service
//  irq_err     out  1        1-cycle pulse: eoi with wrong ID or while not busy
//  pending     out  NUM_SRC  current pending vector, for debug/CSR read
// BEHAVIOUR
//  Reset: irq_req=0, irq_id=0, active_id=0, busy=0, irq_err=0, pending=0, irq_en=0, state=IDLE.
//  Reset is asynchronous and applies immediately mid-handshake. All in-service state is discarded.
//  Pending: edge source: bit sets on sampled 0->1 (prev-sample register, reset 0) and clears on claim.
//    Level source: bit = sampled line every cycle, no latching, never cleared by claim.
//    Same-cycle set and claim-clear on the same edge bit: set wins, so the bit stays pending.
//  eligible = pending & irq_en. Winner = highest set index, so bit NUM_SRC-1 has top priority.
//  irq_en: loaded from cfg_wdata on cfg_we. Decisions in the same cycle use the old value.
//  FSM (registered outputs):
//   IDLE:    |eligible -> REQ. irq_req=1 and irq_id=winner from next cycle.
//   REQ:     irq_id re-evaluates every cycle, so a higher-priority arrival replaces it.
//            eligible==0 -> IDLE (irq_req drops).
//            irq_ack=1 -> SERVICE: active_id<=irq_id, busy<=1, irq_req<=0, edge pending bit cleared.
//            ack has priority over eligible dropping in the same cycle only when eligible!=0.
//   SERVICE: eoi && eoi_id==active_id -> IDLE, busy<=0. Re-request possible on the following cycle.
//            eoi with mismatched ID -> irq_err pulse, stay in SERVICE.
//  eoi in IDLE/REQ: irq_err pulse, no state change. irq_ack outside REQ is ignored.
//  Latency (no sync): edge on irq_src sampled at t -> pending at t+1 -> irq_req at t+2.
//  Interrupts arriving during SERVICE accumulate in pending. No preemption.
// CONFIGURATION
//  IRQ_SYNC_EN defined: irq_src passes through a 2-flop synchronizer (reset 0) before edge/level
//    logic, and all input-to-irq_req latencies grow by 2 cycles.
//  IRQ_SYNC_EN undefined: irq_src is used directly and must be synchronous to clk.
// STRUCTURE
//  irq_defs.vh (shared package): FSM state encodings IRQ_IDLE/IRQ_REQ/IRQ_SERVICE,
//    default NUM_SRC and ID_W, shared with the core's CSR decode.
//  Sub-module irq_prio_enc: parameterised combinational highest-index-wins encoder with a valid
//    output; all-zero input gives id=0, valid=0.
// TESTING
//  1 reset, irq_en=0, irq_src=16'hFFFF -> irq_req stays 0, pending=16'hFFFF (level).
//  2 irq_en=16'hFFFF, EDGE_MASK=16'h00F0, pulse src 5 one cycle -> irq_req=1, irq_id=5 two cycles later;
//    ack -> busy=1, active_id=5, pending[5]=0; eoi,eoi_id=5 -> busy=0.
//  3 level srcs 3 and 9 high -> irq_id=9; ack, eoi 9, drop src 9 -> next request irq_id=3.
//  4 in REQ with irq_id=4, src 12 rises -> irq_id becomes 12 before ack; ack claims 12.
//  5 SERVICE id 7, eoi_id=2 -> irq_err 1-cycle pulse, busy stays 1; eoi in IDLE -> irq_err pulse.
//  6 rst_n low during SERVICE -> all outputs 0 asynchronously; with IRQ_SYNC_EN, case 2 latency=4.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings and default sizing,
// also consumed by the core's CSR decode.
package irq_controller_pkg;

  localparam int IRQ_NUM_SRC_DEF = 16;
  localparam int IRQ_ID_W_DEF    = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Highest-index-wins priority encoder; an all-zero input yields id=0, valid=0.
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int N = IRQ_NUM_SRC_DEF,
  parameter int W = IRQ_ID_W_DEF
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] id,
  output logic         valid
);

  always_comb begin
    id = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) id = W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending capture, enable masking, priority pick and req/ack/eoi handshake.
// Optional build macro IRQ_SYNC_EN adds a 2-flop synchronizer on irq_src.
//
// state       | meaning
// IRQ_IDLE    | nothing presented, nothing in service
// IRQ_REQ     | irq_req high, irq_id tracks the current winner until acked
// IRQ_SERVICE | active_id in service, waiting for matching eoi
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                 NUM_SRC   = IRQ_NUM_SRC_DEF,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
  parameter int                 ID_W      = IRQ_ID_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  input  logic               irq_ack,
  input  logic               eoi,
  input  logic [ID_W-1:0]    eoi_id,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [ID_W-1:0]    active_id,
  output logic               busy,
  output logic               irq_err,
  output logic [NUM_SRC-1:0] pending
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] irq_en;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] claim_clr;
  logic [ID_W-1:0]    winner;
  logic               win_valid;
  logic               claim;
  irq_state_e         state;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = irq_src;
`endif

  assign eligible  = pending & irq_en;
  assign rise      = src_s & ~src_prev;
  assign claim     = (state == IRQ_REQ) && irq_ack && win_valid;
  assign claim_clr = claim ? (NUM_SRC'(1) << irq_id) : '0;

  irq_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .id    (winner),
    .valid (win_valid)
  );

  // A rising edge in the claim cycle re-sets the bit, so set wins over claim-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_prev <= '0;
      irq_en   <= '0;
      pending  <= '0;
    end else begin
      src_prev <= src_s;
      if (cfg_we) irq_en <= cfg_wdata;
      pending  <= (EDGE_MASK & ((pending & ~claim_clr) | rise)) | (~EDGE_MASK & src_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IRQ_IDLE;
      irq_req   <= 1'b0;
      irq_id    <= '0;
      active_id <= '0;
      busy      <= 1'b0;
      irq_err   <= 1'b0;
    end else begin
      irq_err <= 1'b0;
      case (state)
        IRQ_IDLE: begin
          if (eoi) irq_err <= 1'b1;
          if (win_valid) begin
            state   <= IRQ_REQ;
            irq_req <= 1'b1;
            irq_id  <= winner;
          end
        end
        IRQ_REQ: begin
          if (eoi) irq_err <= 1'b1;
          if (!win_valid) begin
            state   <= IRQ_IDLE;
            irq_req <= 1'b0;
          end else if (irq_ack) begin
            state     <= IRQ_SERVICE;
            irq_req   <= 1'b0;
            active_id <= irq_id;
            busy      <= 1'b1;
          end else begin
            irq_id <= winner;
          end
        end
        IRQ_SERVICE: begin
          if (eoi) begin
            if (eoi_id == active_id) begin
              state <= IRQ_IDLE;
              busy  <= 1'b0;
            end else begin
              irq_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IRQ_IDLE;
          irq_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a scoreboard of expected request IDs/latencies.
module tb_irq_controller;

  localparam int N = 16;
  localparam int W = 4;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         cfg_we = 1'b0;
  logic [N-1:0] cfg_wdata = '0;
  logic         irq_ack = 1'b0;
  logic         eoi = 1'b0;
  logic [W-1:0] eoi_id = '0;
  logic         irq_req;
  logic [W-1:0] irq_id;
  logic [W-1:0] active_id;
  logic         busy;
  logic         irq_err;
  logic [N-1:0] pending;

  int tests = 0;
  int fails = 0;
  string       sb_tag[$];
  logic [31:0] sb_val[$];

  irq_controller #(
    .NUM_SRC   (N),
    .EDGE_MASK (16'h00F0),
    .ID_W      (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .eoi_id    (eoi_id),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .active_id (active_id),
    .busy      (busy),
    .irq_err   (irq_err),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (sb_val.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL sb_empty observed=0x%0h expected=none", obs);
    end else begin
      check(sb_tag.pop_front(), obs, sb_val.pop_front());
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n counts clock steps since the stimulus was driven; bounded so a dead DUT cannot hang.
  task automatic wait_req(input int start, output int n);
    n = start;
    while (!irq_req && n < 20) begin
      step(1);
      n++;
    end
  endtask

  task automatic pulse_src(input int i);
    irq_src[i] = 1'b1;
    step(1);
    irq_src[i] = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi(input logic [W-1:0] id);
    eoi    = 1'b1;
    eoi_id = id;
    step(1);
    eoi    = 1'b0;
  endtask

  initial begin
    int n;

    // reset state
    step(2);
    check("rst_irq_req", 32'(irq_req), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_active_id", 32'(active_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq_err", 32'(irq_err), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;
    step(1);

    // T1: all sources high, nothing enabled
    irq_src = '1;
    step(LAT + 1);
    check("t1_pending", 32'(pending), 32'h0000FFFF);
    check("t1_no_req", 32'(irq_req), 32'd0);
    irq_src = '0;
    rst_n   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(LAT + 1);
    check("t1_pending_cleared", 32'(pending), 32'd0);

    // T2: edge source 5, latency and full handshake
    cfg_we    = 1'b1;
    cfg_wdata = 16'hFFFF;
    step(1);
    cfg_we = 1'b0;
    sb_push("t2_latency", 32'(LAT));
    sb_push("t2_id", 32'd5);
    pulse_src(5);
    wait_req(1, n);
    sb_check(32'(n));
    sb_check(32'(irq_id));
    check("t2_pending5", 32'(pending[5]), 32'd1);
    do_ack();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_active", 32'(active_id), 32'd5);
    check("t2_pending5_clr", 32'(pending[5]), 32'd0);
    check("t2_req_drop", 32'(irq_req), 32'd0);
    do_eoi(4'd5);
    check("t2_eoi_busy", 32'(busy), 32'd0);
    check("t2_eoi_err", 32'(irq_err), 32'd0);

    // T3: level sources 3 and 9
    sb_push("t3_id9", 32'd9);
    irq_src[3] = 1'b1;
    irq_src[9] = 1'b1;
    wait_req(0, n);
    sb_check(32'(irq_id));
    do_ack();
    check("t3_active9", 32'(active_id), 32'd9);
    irq_src[9] = 1'b0;
    do_eoi(4'd9);
    check("t3_eoi_busy", 32'(busy), 32'd0);
    step(LAT + 2);
    check("t3_req3", 32'(irq_req), 32'd1);
    check("t3_id3", 32'(irq_id), 32'd3);
    check("t3_level_pending", 32'(pending[3]), 32'd1);
    do_ack();
    check("t3_active3", 32'(active_id), 32'd3);
    irq_src[3] = 1'b0;
    do_eoi(4'd3);
    step(LAT + 2);
    check("t3_idle", 32'(irq_req), 32'd0);

    // T4: higher-priority arrival replaces the presented ID before ack
    sb_push("t4_id4", 32'd4);
    pulse_src(4);
    wait_req(1, n);
    sb_check(32'(irq_id));
    sb_push("t4_id12", 32'd12);
    irq_src[12] = 1'b1;
    step(LAT);
    sb_check(32'(irq_id));
    check("t4_req_held", 32'(irq_req), 32'd1);
    do_ack();
    check("t4_active12", 32'(active_id), 32'd12);
    check("t4_pending4_kept", 32'(pending[4]), 32'd1);
    irq_src[12] = 1'b0;
    do_eoi(4'd12);
    step(LAT + 2);
    check("t4_rereq4", 32'(irq_id), 32'd4);
    do_ack();
    check("t4_active4", 32'(active_id), 32'd4);
    check("t4_pending4_clr", 32'(pending[4]), 32'd0);
    do_eoi(4'd4);
    check("t4_eoi_busy", 32'(busy), 32'd0);

    // T5: wrong-ID eoi in service, eoi while idle
    sb_push("t5_id7", 32'd7);
    pulse_src(7);
    wait_req(1, n);
    sb_check(32'(irq_id));
    do_ack();
    check("t5_active7", 32'(active_id), 32'd7);
    do_eoi(4'd2);
    check("t5_err_pulse", 32'(irq_err), 32'd1);
    check("t5_busy_kept", 32'(busy), 32'd1);
    step(1);
    check("t5_err_drop", 32'(irq_err), 32'd0);
    do_eoi(4'd7);
    check("t5_eoi_busy", 32'(busy), 32'd0);
    check("t5_eoi_ok_err", 32'(irq_err), 32'd0);
    do_eoi(4'd0);
    check("t5_idle_err", 32'(irq_err), 32'd1);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_req", 32'(irq_req), 32'd0);
    step(1);
    check("t5_idle_err_drop", 32'(irq_err), 32'd0);

    // T6: asynchronous reset during service
    sb_push("t6_id6", 32'd6);
    pulse_src(6);
    wait_req(1, n);
    sb_check(32'(irq_id));
    do_ack();
    check("t6_busy", 32'(busy), 32'd1);
    irq_src[10] = 1'b1;
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(irq_req), 32'd0);
    check("t6_rst_id", 32'(irq_id), 32'd0);
    check("t6_rst_active", 32'(active_id), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_err", 32'(irq_err), 32'd0);
    check("t6_rst_pending", 32'(pending), 32'd0);
    irq_src = '0;
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
